hydra_packet_router: RTL and testbench

- Parametrised packet router for one node of a hydra chip network.
- Takes already-deserialised WIDTH-bit packets from NUM_PORTS neighbour links and from the local digital core.
- Routes upstream traffic toward the FPGA. Routes downstream (configuration) traffic to the local core and to all non-upstream neighbours.
- Sits between the per-port UART RX/TX and the chip's config/event logic. Generalises the fixed 4-port wiring to any port count and any upstream assignment.

---
 rtl/hydra_pkg.sv | 21 ++
 rtl/hydra_fifo.sv | 46 ++++
 rtl/hydra_packet_router.sv | 183 ++++++++++++++++++
 tb/tb_hydra_packet_router.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hydra_pkg.sv
// Shared types, constants and helpers for the hydra packet router.
package hydra_pkg;

  localparam int unsigned PKT_W_MAX = 256;
  localparam int unsigned CHIP_ID_W = 8;
  localparam logic [CHIP_ID_W-1:0] BROADCAST_ID = 8'hFF;

  // Packets are zero-extended to PKT_W_MAX so these helpers serve any router WIDTH.
  typedef logic [PKT_W_MAX-1:0] packet_t;

  function automatic logic [CHIP_ID_W-1:0] get_chip_id(input packet_t pkt,
                                                       input int unsigned lsb);
    return CHIP_ID_W'(pkt >> lsb);
  endfunction

  // Zero padding leaves parity unchanged, so the reduction covers the real bits only.
  function automatic logic odd_parity_ok(input packet_t pkt);
    return ^pkt;
  endfunction

endpackage

// File: rtl/hydra_fifo.sv
// Synchronous FIFO with registered storage output (no fall-through) and async active-high reset.
module hydra_fifo #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned AW = $clog2(Depth);

  logic [Depth-1:0][Width-1:0] mem_q;
  logic [AW:0]                 wr_q, wr_d, rd_q, rd_d;
  logic                        do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign data_o  = mem_q[rd_q[AW-1:0]];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
    end else begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

endmodule

// File: rtl/hydra_packet_router.sv
// Per-node packet router: round-robin ingress into up/down FIFOs, multicast egress with done bits.
// Optional HYDRA_PARITY_CHECK_EN: bad-parity ingress packets are accepted, dropped and counted.
module hydra_packet_router
  import hydra_pkg::*;
#(
  parameter int unsigned NUM_PORTS     = 4,
  parameter int unsigned WIDTH         = 64,
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned CHIP_ID_LSB   = 2,
  parameter int unsigned DROP_CNT_BITS = 16
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [CHIP_ID_W-1:0]             chip_id_i,
  input  logic [NUM_PORTS-1:0]             upstream_mask_i,
  input  logic [NUM_PORTS-1:0][WIDTH-1:0]  rx_data_i,
  input  logic [NUM_PORTS-1:0]             rx_valid_i,
  output logic [NUM_PORTS-1:0]             rx_ready_o,
  output logic [NUM_PORTS-1:0][WIDTH-1:0]  tx_data_o,
  output logic [NUM_PORTS-1:0]             tx_valid_o,
  input  logic [NUM_PORTS-1:0]             tx_ready_i,
  input  logic [WIDTH-1:0]                 core_in_data_i,
  input  logic                             core_in_valid_i,
  output logic                             core_in_ready_o,
  output logic [WIDTH-1:0]                 core_out_data_o,
  output logic                             core_out_valid_o,
  input  logic                             core_out_ready_i,
  output logic [DROP_CNT_BITS-1:0]         drop_count_o
);
  localparam int unsigned NR_UP = NUM_PORTS + 1;
  localparam int unsigned UPW   = $clog2(NR_UP);
  localparam int unsigned DNW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned DCW   = DROP_CNT_BITS + 1;

  // First requester at or after ptr in cyclic order; returns n when nobody requests.
  function automatic int unsigned rr_pick(input logic [NUM_PORTS:0] req, input int unsigned n,
                                          input int unsigned ptr);
    logic               found;
    int unsigned        idx;
    logic [NUM_PORTS:0] rot;
    found   = 1'b0;
    rr_pick = n;
    for (int unsigned k = 0; k < NR_UP; k++) begin
      idx = ptr + k;
      if (idx >= n) idx = idx - n;
      rot = req >> idx;
      if (!found && k < n && rot[0]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  logic [UPW-1:0]           up_ptr_q, up_ptr_d;
  logic [DNW-1:0]           dn_ptr_q, dn_ptr_d;
  logic [NUM_PORTS-1:0]     up_done_q, up_done_d, up_vld, up_acc_out;
  logic [NUM_PORTS:0]       dn_done_q, dn_done_d, dn_vld, dn_acc_out, dn_tgt, dn_rdy;
  logic [NUM_PORTS:0]       up_req, dn_req;
  logic [DROP_CNT_BITS-1:0] drop_q, drop_d;
  logic [DCW-1:0]           drop_sum;
  logic [2:0]               drop_inc;
  int unsigned              up_win, dn_win;
  logic [WIDTH-1:0]         up_in, dn_in, up_head, dn_head;
  logic                     up_full, up_empty, dn_full, dn_empty;
  logic                     up_acc, dn_acc, up_par_ok, dn_par_ok, up_pop, dn_pop;
  logic [CHIP_ID_W-1:0]     dn_id;
  logic                     dn_bcast, dn_self;

  // Ingress: requests, grants and ready
  always_comb begin
    up_req = '0;
    dn_req = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      up_req[i] = rx_valid_i[i] & ~upstream_mask_i[i];
      dn_req[i] = rx_valid_i[i] & upstream_mask_i[i];
    end
    up_req[NUM_PORTS] = core_in_valid_i;
  end

  assign up_win = rr_pick(up_req, NR_UP, 32'(up_ptr_q));
  assign dn_win = rr_pick(dn_req, NUM_PORTS, 32'(dn_ptr_q));
  assign up_acc = (up_win != NR_UP) & ~up_full & ~reset_i;
  assign dn_acc = (dn_win != NUM_PORTS) & ~dn_full & ~reset_i;

  always_comb begin
    up_in = core_in_data_i;
    dn_in = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (up_win == i) up_in = rx_data_i[i];
      if (dn_win == i) dn_in = rx_data_i[i];
      rx_ready_o[i] = upstream_mask_i[i] ? (dn_acc && dn_win == i) : (up_acc && up_win == i);
    end
    core_in_ready_o = up_acc && (up_win == NUM_PORTS);
  end

`ifdef HYDRA_PARITY_CHECK_EN
  assign up_par_ok = odd_parity_ok(packet_t'(up_in));
  assign dn_par_ok = odd_parity_ok(packet_t'(dn_in));
`else
  assign up_par_ok = 1'b1;
  assign dn_par_ok = 1'b1;
`endif

  always_comb begin
    up_ptr_d = up_ptr_q;
    dn_ptr_d = dn_ptr_q;
    if (up_acc) up_ptr_d = (up_win == NR_UP - 1) ? '0 : UPW'(up_win + 1);
    if (dn_acc) dn_ptr_d = (dn_win == NUM_PORTS - 1) ? '0 : DNW'(dn_win + 1);
  end

  hydra_fifo #(.Width(WIDTH), .Depth(FIFO_DEPTH)) u_up_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .push_i (up_acc & up_par_ok),
    .data_i (up_in),
    .pop_i  (up_pop),
    .data_o (up_head),
    .full_o (up_full),
    .empty_o(up_empty)
  );

  hydra_fifo #(.Width(WIDTH), .Depth(FIFO_DEPTH)) u_down_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .push_i (dn_acc & dn_par_ok),
    .data_i (dn_in),
    .pop_i  (dn_pop),
    .data_o (dn_head),
    .full_o (dn_full),
    .empty_o(dn_empty)
  );

  // Egress: head is multicast; it pops once every target is done or accepting now
  assign up_vld     = {NUM_PORTS{~up_empty}} & upstream_mask_i & ~up_done_q;
  assign up_acc_out = up_vld & tx_ready_i;
  assign up_pop     = ~up_empty & (&(~upstream_mask_i | up_done_q | up_acc_out));
  assign up_done_d  = up_pop ? '0 : (up_done_q | up_acc_out);

  assign dn_id    = get_chip_id(packet_t'(dn_head), CHIP_ID_LSB);
  assign dn_bcast = (dn_id == BROADCAST_ID);
  assign dn_self  = (dn_id == chip_id_i);
  assign dn_tgt   = {dn_bcast | dn_self, (dn_bcast | ~dn_self) ? ~upstream_mask_i : '0};
  assign dn_rdy   = {core_out_ready_i, tx_ready_i};

  assign dn_vld     = {NR_UP{~dn_empty}} & dn_tgt & ~dn_done_q;
  assign dn_acc_out = dn_vld & dn_rdy;
  assign dn_pop     = ~dn_empty & (&(~dn_tgt | dn_done_q | dn_acc_out));
  assign dn_done_d  = dn_pop ? '0 : (dn_done_q | dn_acc_out);

  always_comb begin
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      tx_valid_o[i] = upstream_mask_i[i] ? up_vld[i] : dn_vld[i];
      tx_data_o[i]  = upstream_mask_i[i] ? up_head : dn_head;
    end
  end

  assign core_out_valid_o = dn_vld[NUM_PORTS];
  assign core_out_data_o  = dn_head;

  // Drops: empty target sets plus parity rejects, saturating
  assign drop_inc = {2'b00, up_pop & ~|upstream_mask_i} + {2'b00, dn_pop & ~|dn_tgt}
                  + {2'b00, up_acc & ~up_par_ok} + {2'b00, dn_acc & ~dn_par_ok};
  assign drop_sum = {1'b0, drop_q} + DCW'(drop_inc);
  assign drop_d   = drop_sum[DROP_CNT_BITS] ? '1 : drop_sum[DROP_CNT_BITS-1:0];
  assign drop_count_o = drop_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      up_ptr_q  <= '0;
      dn_ptr_q  <= '0;
      up_done_q <= '0;
      dn_done_q <= '0;
      drop_q    <= '0;
    end else begin
      up_ptr_q  <= up_ptr_d;
      dn_ptr_q  <= dn_ptr_d;
      up_done_q <= up_done_d;
      dn_done_q <= dn_done_d;
      drop_q    <= drop_d;
    end
  end

endmodule

// File: tb/tb_hydra_packet_router.sv
// Directed bench for hydra_packet_router: per-output expected queues built from routing rules.
`timescale 1ns/100ps
module tb_hydra_packet_router;
  localparam int unsigned NP  = 4;
  localparam int unsigned W   = 64;
  localparam int unsigned LSB = 2;
  localparam int unsigned NS  = NP + 1;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [7:0]           chip_id = 8'h05;
  logic [NP-1:0]        mask = 4'b1000;
  logic [NP-1:0][W-1:0] rx_data = '0;
  logic [NP-1:0]        rx_valid = '0;
  logic [NP-1:0]        rx_ready;
  logic [NP-1:0][W-1:0] tx_data;
  logic [NP-1:0]        tx_valid;
  logic [NP-1:0]        tx_ready = '1;
  logic [W-1:0]         cin_data = '0;
  logic                 cin_valid = 1'b0;
  logic                 cin_ready;
  logic [W-1:0]         cout_data;
  logic                 cout_valid;
  logic                 cout_ready = 1'b1;
  logic [15:0]          drop_count;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] src_q[NS][$];
  logic [W-1:0] exp_q[NS][$];
  int out_cnt[NS];
  int acc_cnt[NS];
  int snap_out[NS];
  int snap_acc[NS];
  int up_log[$];
  int exp_drops = 0;
  logic [NS-1:0] drv_acc;
  logic mv, mr;
  logic [W-1:0] md;

  always #5 clk = ~clk;

  hydra_packet_router dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .chip_id_i       (chip_id),
    .upstream_mask_i (mask),
    .rx_data_i       (rx_data),
    .rx_valid_i      (rx_valid),
    .rx_ready_o      (rx_ready),
    .tx_data_o       (tx_data),
    .tx_valid_o      (tx_valid),
    .tx_ready_i      (tx_ready),
    .core_in_data_i  (cin_data),
    .core_in_valid_i (cin_valid),
    .core_in_ready_o (cin_ready),
    .core_out_data_o (cout_data),
    .core_out_valid_o(cout_valid),
    .core_out_ready_i(cout_ready),
    .drop_count_o    (drop_count)
  );

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  // Packet with ID field and tag, top bit set for odd overall parity.
  function automatic logic [W-1:0] mk(input logic [7:0] id, input logic [31:0] tag);
    logic [W-1:0] p;
    p = '0;
    p[LSB +: 8] = id;
    p[47:16] = tag;
    p[W-1] = ~(^p[W-2:0]);
    return p;
  endfunction

  function automatic logic s_valid(input int s);
    return (s == NP) ? cin_valid : rx_valid[s];
  endfunction
  function automatic logic s_ready(input int s);
    return (s == NP) ? cin_ready : rx_ready[s];
  endfunction
  function automatic logic [W-1:0] s_data(input int s);
    return (s == NP) ? cin_data : rx_data[s];
  endfunction

  // Routing model: where must an accepted packet end up?
  task automatic model_accept(input int s, input logic [W-1:0] p);
    logic [7:0] id;
    bit hit;
    acc_cnt[s]++;
`ifdef HYDRA_PARITY_CHECK_EN
    if (^p == 1'b0) begin
      exp_drops++;
      return;
    end
`endif
    if (s == NP || !mask[s]) begin
      up_log.push_back(s);
      if (mask == '0) exp_drops++;
      for (int o = 0; o < NP; o++) if (mask[o]) exp_q[o].push_back(p);
    end else begin
      id  = p[LSB +: 8];
      hit = 0;
      if (id == chip_id || id == 8'hFF) begin
        exp_q[NP].push_back(p);
        hit = 1;
      end
      if (id != chip_id || id == 8'hFF)
        for (int o = 0; o < NP; o++) if (!mask[o]) begin
          exp_q[o].push_back(p);
          hit = 1;
        end
      if (!hit) exp_drops++;
    end
  endtask

  // Compare process: every output transfer must match the head of its expected queue.
  always @(negedge clk) begin
    if (!reset) begin
      for (int o = 0; o < NS; o++) begin
        mv = (o == NP) ? cout_valid : tx_valid[o];
        mr = (o == NP) ? cout_ready : tx_ready[o];
        md = (o == NP) ? cout_data : tx_data[o];
        if (mv && mr) begin
          out_cnt[o]++;
          if (exp_q[o].size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL out%0d unexpected: got %h required nothing", o, md);
          end else begin
            check($sformatf("out%0d data", o), md, exp_q[o].pop_front());
          end
        end
      end
      for (int s = 0; s < NS; s++) if (s_valid(s) && s_ready(s)) model_accept(s, s_data(s));
    end
  end

  // Source driver: holds valid/data until accepted.
  always begin
    @(negedge clk);
    for (int s = 0; s < NS; s++) drv_acc[s] = s_valid(s) && s_ready(s);
    @(posedge clk);
    #1;
    for (int s = 0; s < NS; s++) begin
      if (drv_acc[s] && src_q[s].size() > 0) void'(src_q[s].pop_front());
      if (s == NP) begin
        cin_valid = (src_q[s].size() > 0);
        cin_data  = cin_valid ? src_q[s][0] : '0;
      end else begin
        rx_valid[s] = (src_q[s].size() > 0);
        rx_data[s]  = rx_valid[s] ? src_q[s][0] : '0;
      end
    end
  end

  function automatic bit quiet();
    for (int s = 0; s < NS; s++) if (src_q[s].size() != 0 || exp_q[s].size() != 0) return 0;
    return 1;
  endfunction

  task automatic wait_quiet(input string name);
    int n;
    n = 0;
    while (n < 400 && !quiet()) begin
      @(posedge clk);
      n++;
    end
    if (!quiet()) begin
      vectors++;
      miscompares++;
      $display("FAIL %s drain: got pending traffic after %0d cycles, required empty", name, n);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    snap_out = out_cnt;
    snap_acc = acc_cnt;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rr_exp[4];
    logic [W-1:0] p;
    rr_exp = '{0, 1, 2, 4};
    for (int s = 0; s < NS; s++) begin
      out_cnt[s] = 0;
      acc_cnt[s] = 0;
    end
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst tx_valid", W'(tx_valid), '0);
    check("rst rx_ready", W'(rx_ready), '0);
    check("rst core_in_ready", W'(cin_ready), '0);
    check("rst core_out_valid", W'(cout_valid), '0);
    check("rst drop_count", W'(drop_count), '0);
    check("rst core_out_data", cout_data, '0);
    for (int i = 0; i < NP; i++) check($sformatf("rst tx_data%0d", i), tx_data[i], '0);

    // Self-addressed downstream packet: core only
    snap();
    src_q[3].push_back(mk(8'h05, 32'h1));
    wait_quiet("self");
    check("self core_out count", W'(out_cnt[NP] - snap_out[NP]), 1);
    for (int o = 0; o < 3; o++) check($sformatf("self tx%0d count", o), W'(out_cnt[o] - snap_out[o]), 0);

    // Broadcast with port 1 stalled: no re-send on 0/2, no pop before port 1 accepts
    snap();
    tx_ready[1] = 1'b0;
    src_q[3].push_back(mk(8'hFF, 32'h2));
    repeat (9) @(posedge clk);
    #1;
    check("bcast tx0 once", W'(out_cnt[0] - snap_out[0]), 1);
    check("bcast tx2 once", W'(out_cnt[2] - snap_out[2]), 1);
    check("bcast core once", W'(out_cnt[NP] - snap_out[NP]), 1);
    check("bcast tx1 stalled", W'(out_cnt[1] - snap_out[1]), 0);
    check("bcast tx1 valid held", W'(tx_valid[1]), 1);
    check("bcast tx0 not re-presented", W'(tx_valid[0]), 0);
    tx_ready[1] = 1'b1;
    wait_quiet("bcast");
    check("bcast tx1 once", W'(out_cnt[1] - snap_out[1]), 1);
    check("bcast tx0 still once", W'(out_cnt[0] - snap_out[0]), 1);

    // Round-robin fairness from reset pointers
    reset = 1'b1;
    #3 reset = 1'b0;
    exp_drops = 0;
    up_log.delete();
    snap();
    for (int k = 0; k < 12; k++) begin
      src_q[0].push_back(mk(8'h30, 32'h100 + k));
      src_q[1].push_back(mk(8'h31, 32'h200 + k));
      src_q[2].push_back(mk(8'h32, 32'h300 + k));
      src_q[NP].push_back(mk(8'h33, 32'h400 + k));
    end
    wait_quiet("rr");
    check("rr port3 count", W'(out_cnt[3] - snap_out[3]), 48);
    check("rr log size", W'(up_log.size()), 48);
    for (int i = 0; i < 48 && i < up_log.size(); i++)
      check($sformatf("rr order[%0d]", i), W'(up_log[i]), W'(rr_exp[i % 4]));

    // Backpressure: FIFO depth 8 fills, 9th stalls, all 9 delivered in order
    snap();
    tx_ready[3] = 1'b0;
    for (int k = 0; k < 9; k++) src_q[0].push_back(mk(8'h40, 32'h500 + k));
    repeat (20) @(posedge clk);
    #1;
    check("full accepted", W'(acc_cnt[0] - snap_acc[0]), 8);
    check("full rx_ready low", W'(rx_ready[0]), 0);
    check("full tx3 valid", W'(tx_valid[3]), 1);
    tx_ready[3] = 1'b1;
    wait_quiet("full");
    check("full delivered", W'(out_cnt[3] - snap_out[3]), 9);
    check("full accepted total", W'(acc_cnt[0] - snap_acc[0]), 9);

    // Empty target set: all ports upstream, foreign ID
    mask = 4'b1111;
    snap();
    check("drop before", W'(drop_count), 0);
    src_q[0].push_back(mk(8'h22, 32'h7));
    wait_quiet("drop");
    check("drop after", W'(drop_count), 1);
    check("drop model", W'(drop_count), W'(exp_drops));
    check("drop core silent", W'(out_cnt[NP] - snap_out[NP]), 0);
`ifdef HYDRA_PARITY_CHECK_EN
    p = mk(8'h05, 32'h9);
    p[W-1] = ~p[W-1];
    src_q[NP].push_back(p);
    wait_quiet("parity");
    check("parity drop", W'(drop_count), 2);
    check("parity model", W'(drop_count), W'(exp_drops));
    for (int o = 0; o < NP; o++) check($sformatf("parity tx%0d silent", o), W'(out_cnt[o] - snap_out[o]), 0);
`endif

    // Reset mid-operation with 3 packets queued
    mask = 4'b1000;
    tx_ready[3] = 1'b0;
    for (int k = 0; k < 3; k++) src_q[0].push_back(mk(8'h50, 32'h600 + k));
    repeat (8) @(posedge clk);
    #2;
    check("mid tx3 valid before", W'(tx_valid[3]), 1);
    reset = 1'b1;
    #0.5;
    check("mid tx_valid", W'(tx_valid), '0);
    check("mid core_out_valid", W'(cout_valid), '0);
    check("mid rx_ready", W'(rx_ready), '0);
    #0.5 reset = 1'b0;
    for (int s = 0; s < NS; s++) begin
      exp_q[s].delete();
      src_q[s].delete();
    end
    exp_drops = 0;
    snap();
    tx_ready[3] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post tx_valid", W'(tx_valid), '0);
    check("post drop_count", W'(drop_count), 0);
    src_q[1].push_back(mk(8'h11, 32'h700));
    wait_quiet("post");
    check("post routed", W'(out_cnt[3] - snap_out[3]), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
